// File: rtl/lenet_pkg.sv
// ============================================================================
// lenet_pkg : shared constants and types for the LeNet conv datapath
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef LENET_PIX
`define LENET_PIX(k, bw) ((bw)*((k)+1)-1):((bw)*(k))
`endif

package lenet_pkg;

  localparam int CH            = 16;
  localparam int KSIZE         = 5;
  localparam int BIT_WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } feed_state_t;

endpackage

`default_nettype wire

// File: rtl/line_delay.sv
// ============================================================================
// line_delay : one image-row delay, combinational read then write at idx
// Rev 1.0
// ============================================================================
`default_nettype none

module line_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Contents are never reset; stale entries are masked by the window logic.
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign dout = r_mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window_feeder55_16.sv
// ============================================================================
// window_feeder55_16 : raster pixel stream to 5-row columns for conv55_16
// Rev 1.0
// ============================================================================
`default_nettype none

module window_feeder55_16
  import lenet_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int IMG_W     = 5,
  parameter int IMG_H     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  input  logic [CH*BIT_WIDTH-1:0]    pix_data,
  input  logic                       flush,
  output logic [CH*BIT_WIDTH-1:0]    in1,
  output logic [CH*BIT_WIDTH-1:0]    in2,
  output logic [CH*BIT_WIDTH-1:0]    in3,
  output logic [CH*BIT_WIDTH-1:0]    in4,
  output logic [CH*BIT_WIDTH-1:0]    in5,
  output logic                       en,
  output logic                       window_valid,
  output logic                       frame_done,
  output logic [$clog2(IMG_H)-1:0]   row_idx,
  output logic [$clog2(IMG_W)-1:0]   col_idx
);

  localparam int PW   = CH * BIT_WIDTH;
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int NDLY = KSIZE - 1;

  localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_fill = RW'(KSIZE - 2);
  localparam logic [CW-1:0] c_col_win  = CW'(KSIZE - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  feed_state_t   r_state;

  logic          w_we;
  logic          w_col_wrap;
  logic          w_last;
  logic [PW-1:0] w_din  [NDLY];
  logic [PW-1:0] w_dout [NDLY];

  assign w_we       = pix_valid && !flush && !rst;
  assign w_col_wrap = (r_col == c_col_last);
  assign w_last     = w_col_wrap && (r_row == c_row_last);

  // Delay k feeds delay k+1, so w_dout[k] is the pixel from k+1 rows above.
  generate
    for (genvar g = 0; g < NDLY; g++) begin : g_delay
      if (g == 0) begin : g_first
        assign w_din[g] = pix_data;
      end else begin : g_chain
        assign w_din[g] = w_dout[g-1];
      end
      line_delay #(
        .DEPTH (IMG_W),
        .WIDTH (PW)
      ) u_dly (
        .clk  (clk),
        .we   (w_we),
        .idx  (r_col),
        .din  (w_din[g]),
        .dout (w_dout[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      in1          <= '0;
      in2          <= '0;
      in3          <= '0;
      in4          <= '0;
      in5          <= '0;
      en           <= 1'b0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      row_idx      <= '0;
      col_idx      <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_state      <= FILL;
    end else if (flush) begin
      en           <= 1'b0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_state      <= FILL;
    end else if (pix_valid) begin
      in5          <= pix_data;
      in4          <= w_dout[0];
      in3          <= w_dout[1];
      in2          <= w_dout[2];
      in1          <= w_dout[3];
      en           <= 1'b1;
      window_valid <= (r_state == RUN) && (r_col >= c_col_win);
      frame_done   <= w_last;
      row_idx      <= r_row;
      col_idx      <= r_col;
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_last) begin
        r_state <= FILL;
      end else if (w_col_wrap && (r_row == c_row_fill)) begin
        r_state <= RUN;
      end
    end else begin
      en           <= 1'b0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_feeder55_16.sv
// ============================================================================
// tb_window_feeder55_16 : scoreboard bench, 5x5 and 8x8 instances in parallel
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_window_feeder55_16;
  import lenet_pkg::*;

  localparam int PW = 128;

  typedef struct {
    int           row;
    int           col;
    logic [PW-1:0] d [5];
    bit [4:0]     m;
    bit           wv;
    bit           fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] pix_data = '0;

  logic [PW-1:0] o_in  [2][5];
  logic          o_en  [2];
  logic          o_wv  [2];
  logic          o_fd  [2];
  logic [2:0]    o_row [2];
  logic [2:0]    o_col [2];

  window_feeder55_16 #(.BIT_WIDTH(8), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .flush(flush),
    .in1(o_in[0][0]), .in2(o_in[0][1]), .in3(o_in[0][2]), .in4(o_in[0][3]), .in5(o_in[0][4]),
    .en(o_en[0]), .window_valid(o_wv[0]), .frame_done(o_fd[0]),
    .row_idx(o_row[0]), .col_idx(o_col[0])
  );

  window_feeder55_16 #(.BIT_WIDTH(8), .IMG_W(8), .IMG_H(8)) dut8 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .flush(flush),
    .in1(o_in[1][0]), .in2(o_in[1][1]), .in3(o_in[1][2]), .in4(o_in[1][3]), .in5(o_in[1][4]),
    .en(o_en[1]), .window_valid(o_wv[1]), .frame_done(o_fd[1]),
    .row_idx(o_row[1]), .col_idx(o_col[1])
  );

  // Reference model: the frame image so far, indexed by (row, col).
  int            dim [2] = '{5, 8};
  int            mr [2];
  int            mc [2];
  logic [PW-1:0] img [2][8][8];
  bit            exp_en [2];
  exp_t          held [2];
  exp_t          q0 [$];
  exp_t          q1 [$];
  int            wcnt [2];
  int            npass = 0;
  int            nchk  = 0;
  bit            started = 1'b0;

  function automatic logic [PW-1:0] pat(input int r, input int c);
    logic [7:0] b;
    b = 8'(5 * r + c);
    return {16{b}};
  endfunction

  task automatic cmp(input string name, input int id, input logic [PW-1:0] act,
                     input logic [PW-1:0] expv);
    nchk++;
    if (act === expv) npass++;
    else $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, id, $time, act, expv);
  endtask

  task automatic model_step(input bit rs, input bit fl, input bit v, input logic [PW-1:0] d);
    exp_t e;
    for (int id = 0; id < 2; id++) begin
      if (rs) begin
        mr[id] = 0; mc[id] = 0; exp_en[id] = 1'b0;
        e.row = 0; e.col = 0; e.m = 5'h1f; e.wv = 1'b0; e.fd = 1'b0;
        for (int k = 0; k < 5; k++) e.d[k] = '0;
        held[id] = e;
      end else if (fl) begin
        mr[id] = 0; mc[id] = 0; exp_en[id] = 1'b0;
      end else if (v) begin
        img[id][mr[id]][mc[id]] = d;
        e.row = mr[id]; e.col = mc[id];
        e.d[4] = d; e.m = 5'h10;
        for (int k = 1; k < 5; k++) begin
          e.d[4-k] = '0;
          if (mr[id] >= k) begin
            e.d[4-k] = img[id][mr[id]-k][mc[id]];
            e.m[4-k] = 1'b1;
          end
        end
        e.wv = (mr[id] >= 4) && (mc[id] >= 4);
        e.fd = (mr[id] == dim[id]-1) && (mc[id] == dim[id]-1);
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        held[id] = e;
        exp_en[id] = 1'b1;
        if (mc[id] == dim[id]-1) begin
          mc[id] = 0;
          mr[id] = (mr[id] == dim[id]-1) ? 0 : mr[id] + 1;
        end else begin
          mc[id] = mc[id] + 1;
        end
      end else begin
        exp_en[id] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit rs, input bit fl, input bit v, input logic [PW-1:0] d);
    rst = rs; flush = fl; pix_valid = v; pix_data = d;
    @(posedge clk);
    model_step(rs, fl, v, d);
    #1;
  endtask

  task automatic check_one(input int id);
    exp_t e;
    bit   have;
    have = 1'b1;
    cmp("en", id, PW'(o_en[id]), PW'(exp_en[id]));
    if (exp_en[id]) begin
      if (id == 0 && q0.size() > 0) e = q0.pop_front();
      else if (id == 1 && q1.size() > 0) e = q1.pop_front();
      else begin
        have = 1'b0;
        cmp("sb_empty", id, PW'(1), PW'(0));
      end
    end else begin
      e = held[id];
      e.wv = 1'b0;
      e.fd = 1'b0;
    end
    if (have) begin
      cmp("row_idx", id, PW'(o_row[id]), PW'(e.row));
      cmp("col_idx", id, PW'(o_col[id]), PW'(e.col));
      cmp("window_valid", id, PW'(o_wv[id]), PW'(e.wv));
      cmp("frame_done", id, PW'(o_fd[id]), PW'(e.fd));
      for (int k = 0; k < 5; k++)
        if (e.m[k]) cmp($sformatf("in%0d", k + 1), id, o_in[id][k], e.d[k]);
      if (exp_en[id]) begin
        if (e.row == 0 && e.col == 0) wcnt[id] = 0;
        if (o_wv[id] === 1'b1) wcnt[id]++;
        if (e.fd) cmp("win_count", id, PW'(wcnt[id]), PW'((dim[id]-4) * (dim[id]-4)));
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_one(0);
      check_one(1);
    end
  end

  initial begin
    int n;
    cycle(1, 0, 0, '0);
    started = 1'b1;
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);

    // Reset mid-frame after 7 pixels, with a pixel offered during reset.
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, pat(i / 5, i % 5));
    cycle(1, 0, 1, pat(9, 9));
    cycle(0, 0, 0, '0);

    // Continuous pattern frame, immediately followed by another.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 25; i++) cycle(0, 0, 1, pat(i / 5, i % 5));
    cycle(0, 0, 0, '0);

    // Random gaps.
    n = 0;
    while (n < 25) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle(0, 0, 1, pat(n / 5, n % 5));
        n++;
      end else begin
        cycle(0, 0, 0, pat(7, 7));
      end
    end

    // Flush at (3,2) with a valid pixel, then a clean frame.
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, pat(i / 5, i % 5));
    cycle(0, 1, 1, pat(3, 2));
    cycle(0, 0, 0, '0);
    for (int i = 0; i < 25; i++) cycle(0, 0, 1, pat(i / 5, i % 5));

    // Align both instances, then two random 8x8 frames back to back.
    cycle(0, 1, 0, '0);
    for (int i = 0; i < 128; i++)
      cycle(0, 0, 1, {$urandom, $urandom, $urandom, $urandom});

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
    cmp("sb_drain", 0, PW'(q0.size()), PW'(0));
    cmp("sb_drain", 1, PW'(q1.size()), PW'(0));
    started = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

`default_nettype wire
